// File: rtl/pipe_seg_skid.sv
// Pipeline segment register with valid/ready handshake and a 2-entry skid buffer.
// Optional duplicated low-slice output register is enabled by defining PIPE_SEG_DUP_EN.
module pipe_seg_skid #(
  parameter int DW   = 32,
  parameter int EXW  = 16,
  parameter int DUPW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            refresh,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [EXW-1:0]  in_ex,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [EXW-1:0]  out_ex,
  output logic [DUPW-1:0] out_dup,
  output logic [1:0]      occ
);

  // The state encoding is the occupancy count, so occ comes straight off the state flops.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    main_data_q, main_data_d;
  logic [EXW-1:0]   main_ex_q, main_ex_d;
  logic [DW-1:0]    skid_data_q, skid_data_d;
  logic [EXW-1:0]   skid_ex_q, skid_ex_d;
  logic             in_fire_s;
  logic             out_fire_s;

  // Handshake signals depend only on state flops, keeping out_ready away from in_ready.
  assign in_ready   = (state_q != ST_TWO);
  assign out_valid  = (state_q != ST_EMPTY);
  assign occ        = state_q;
  assign out_data   = main_data_q;
  assign out_ex     = main_ex_q;
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  // Next-state and datapath selection; refresh overrides any simultaneous transfer.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ex_d   = main_ex_q;
    skid_data_d = skid_data_q;
    skid_ex_d   = skid_ex_q;
    if (refresh) begin
      state_d     = ST_EMPTY;
      main_data_d = {DW{1'b0}};
      main_ex_d   = {EXW{1'b0}};
      skid_data_d = {DW{1'b0}};
      skid_ex_d   = {EXW{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ex_d   = in_ex;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ex_d   = in_ex;
          end else if (in_fire_s) begin
            state_d     = ST_TWO;
            skid_data_d = in_data;
            skid_ex_d   = in_ex;
          end else if (out_fire_s) begin
            // Entry leaves with no replacement: scrub the register.
            state_d     = ST_EMPTY;
            main_data_d = {DW{1'b0}};
            main_ex_d   = {EXW{1'b0}};
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_fire_s) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ex_d   = skid_ex_q;
            skid_data_d = {DW{1'b0}};
            skid_ex_d   = {EXW{1'b0}};
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_data_d = {DW{1'b0}};
          main_ex_d   = {EXW{1'b0}};
          skid_data_d = {DW{1'b0}};
          skid_ex_d   = {EXW{1'b0}};
        end
      endcase
    end
  end

  // State and storage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_EMPTY;
      main_data_q <= {DW{1'b0}};
      main_ex_q   <= {EXW{1'b0}};
      skid_data_q <= {DW{1'b0}};
      skid_ex_q   <= {EXW{1'b0}};
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ex_q   <= main_ex_d;
      skid_data_q <= skid_data_d;
      skid_ex_q   <= skid_ex_d;
    end
  end

`ifdef PIPE_SEG_DUP_EN
  // Separate copy of the low payload slice so wide consumers do not load the main register.
  (* keep = "true" *) logic [DUPW-1:0] dup_q;
  logic [DUPW-1:0] dup_d;

  // Shares its source with the main data register so both always load together.
  always_comb begin
    dup_d = main_data_d[DUPW-1:0];
  end

  // Duplicate register, cleared by reset like the main register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dup_q <= {DUPW{1'b0}};
    end else begin
      dup_q <= dup_d;
    end
  end

  assign out_dup = dup_q;
`else
  assign out_dup = {DUPW{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_seg_skid.sv
// Directed and scoreboard-checked stimulus for pipe_seg_skid (DW=32, EXW=16, DUPW=16).
module tb_pipe_seg_skid;

  localparam int DW   = 32;
  localparam int EXW  = 16;
  localparam int DUPW = 16;

  logic            clk;
  logic            resetn;
  logic            refresh;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [EXW-1:0]  in_ex;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [EXW-1:0]  out_ex;
  logic [DUPW-1:0] out_dup;
  logic [1:0]      occ;

  int n_chk;
  int n_pass;

  pipe_seg_skid #(.DW(DW), .EXW(EXW), .DUPW(DUPW)) dut (
    .clk(clk), .resetn(resetn), .refresh(refresh),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ex(in_ex),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ex(out_ex),
    .out_dup(out_dup), .occ(occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DUPW-1:0] dup_exp(input logic [DW-1:0] d);
`ifdef PIPE_SEG_DUP_EN
    return d[DUPW-1:0];
`else
    return {DUPW{1'b0}};
`endif
  endfunction

  task automatic push(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    in_ex    = d[EXW-1:0] ^ 16'h0100;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [DW-1:0] d, input logic [1:0] o);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'(v));
    check_eq({tag, "_data"}, 64'(out_data), 64'(d));
    check_eq({tag, "_ex"}, 64'(out_ex), v ? 64'(d[EXW-1:0] ^ 16'h0100) : 64'd0);
    check_eq({tag, "_dup"}, 64'(out_dup), 64'(dup_exp(d)));
    check_eq({tag, "_occ"}, 64'(occ), 64'(o));
  endtask

  logic [DW+EXW-1:0] q[$];
  bit model_in_fire;
  bit model_out_fire;
  bit do_refresh;
  logic [DW-1:0] exp_d;
  logic [EXW-1:0] exp_e;

  initial begin
    n_chk = 0; n_pass = 0;
    resetn = 1'b0; refresh = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_ex = 16'd0; out_ready = 1'b0;
    #1;

    // 1: reset
    tick(); tick();
    check_out("rst", 1'b0, 32'd0, 2'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // 2: back-to-back streaming
    resetn = 1'b1; out_ready = 1'b1;
    push(32'h11); tick(); check_out("bb1", 1'b1, 32'h11, 2'd1); check_eq("bb1_rdy", 64'(in_ready), 64'd1);
    push(32'h22); tick(); check_out("bb2", 1'b1, 32'h22, 2'd1); check_eq("bb2_rdy", 64'(in_ready), 64'd1);
    push(32'h33); tick(); check_out("bb3", 1'b1, 32'h33, 2'd1); check_eq("bb3_rdy", 64'(in_ready), 64'd1);
    in_valid = 1'b0; tick(); check_out("bb_drain", 1'b0, 32'd0, 2'd0);

    // 3: fill skid under backpressure, then drain in order
    out_ready = 1'b0;
    push(32'hA); tick(); check_out("bp_a", 1'b1, 32'hA, 2'd1);
    push(32'hB); tick(); check_out("bp_b", 1'b1, 32'hA, 2'd2);
    check_eq("bp_full_rdy", 64'(in_ready), 64'd0);
    push(32'hC); tick(); check_out("bp_hold", 1'b1, 32'hA, 2'd2);
    out_ready = 1'b1; tick(); check_out("dr_b", 1'b1, 32'hB, 2'd1);
    check_eq("dr_rdy", 64'(in_ready), 64'd1);
    tick(); check_out("dr_c", 1'b1, 32'hC, 2'd1);
    in_valid = 1'b0; tick(); check_out("dr_empty", 1'b0, 32'd0, 2'd0);

    // 4: refresh while full discards everything, including the offered entry
    out_ready = 1'b0;
    push(32'h1); tick(); push(32'h2); tick();
    check_eq("rf_pre_occ", 64'(occ), 64'd2);
    refresh = 1'b1; push(32'hD); tick();
    check_out("rf", 1'b0, 32'd0, 2'd0);
    check_eq("rf_rdy", 64'(in_ready), 64'd1);
    refresh = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    check_out("rf_after", 1'b0, 32'd0, 2'd0);

    // 5: simultaneous in/out fire at occupancy one
    out_ready = 1'b0;
    push(32'h5); tick(); check_out("sim_5", 1'b1, 32'h5, 2'd1);
    push(32'h6); out_ready = 1'b1; tick(); check_out("sim_6", 1'b1, 32'h6, 2'd1);
    in_valid = 1'b0; tick(); check_out("sim_empty", 1'b0, 32'd0, 2'd0);

    // 6: random stream against a FIFO model, with occasional refresh and reset
    q.delete();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom();
      in_ex     = 16'($urandom());
      out_ready = ($urandom_range(0, 2) != 0);
      do_refresh = ($urandom_range(0, 39) == 0);
      refresh   = do_refresh && (i % 2 == 0);
      resetn    = !(do_refresh && (i % 2 == 1));
      model_in_fire  = in_valid && (q.size() < 2);
      model_out_fire = (q.size() > 0) && out_ready;
      check_eq("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
      tick();
      if (do_refresh) begin
        q.delete();
      end else begin
        if (model_out_fire) void'(q.pop_front());
        if (model_in_fire) q.push_back({in_ex, in_data});
      end
      if (q.size() > 0) begin
        exp_d = q[0][DW-1:0];
        exp_e = q[0][DW+EXW-1:DW];
      end else begin
        exp_d = 32'd0;
        exp_e = 16'd0;
      end
      check_eq("rnd_valid", 64'(out_valid), 64'(q.size() > 0));
      check_eq("rnd_data", 64'(out_data), 64'(exp_d));
      check_eq("rnd_ex", 64'(out_ex), 64'(exp_e));
      check_eq("rnd_dup", 64'(out_dup), 64'(dup_exp(exp_d)));
      check_eq("rnd_occ", 64'(occ), 64'(q.size()));
    end
    refresh = 1'b0; resetn = 1'b1; in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
